// File: rtl/packet_read_arbiter.sv
// packet_read_arbiter
//   Round-robin arbiter that gives one of two consumers a single burst of up
//   to MAX_BURST bytes from the packet storage FIFO. Requester 0 is the USB
//   transmit engine and requester 1 is the debug/monitor port. The block sits
//   in the FIFO read-clock domain.
//
//   Optional feature: define STALL_TIMEOUT_EN to abort a burst after TIMEOUT
//   consecutive stall cycles. In that case done_x pulses together with abort.
//   Without the macro a stall lasts as long as the FIFO stays empty, and abort
//   is tied to 0.
//
// Ports
//   clk, rst            read-domain clock, synchronous active-high reset
//   req_x, len_x        burst request and byte count per requester
//                       (len_x = 0 is never granted)
//   fifo_ready          FIFO holds at least one complete packet
//   fifo_empty          FIFO empty
//   fifo_r_data         FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en           FIFO read strobe
//   gnt_x               requester x owns the FIFO for the current burst
//   rd_data             pass-through of fifo_r_data
//   rd_valid_x          rd_data holds a byte for requester x
//   done_x              one-cycle pulse at the end of requester x's burst
//   abort               one-cycle pulse with done_x when a burst timed out
//   busy                arbiter is not idle
//
// Handshake: a request is only sampled while idle, and req_x/len_x are ignored
// for the rest of the burst. The consumer gets no backpressure: every cycle
// with rd_valid_x = 1 carries exactly one byte on rd_data, and the consumer
// must take it in that cycle.
module packet_read_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned BURST_W   = 7,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic [BURST_W-1:0] len_0,
  input  logic              req_1,
  input  logic [BURST_W-1:0] len_1,
  input  logic              fifo_ready,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic              fifo_r_en,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid_0,
  output logic              rd_valid_1,
  output logic              done_0,
  output logic              done_1,
  output logic              abort,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(MAX_BURST);

  state_t             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  // Requester that wins a tie. It starts at 0 and is set to the loser of
  // each completed burst, so the last winner is always the one not favoured.
  logic               favour_q, favour_d;
  logic               gnt_0_q, gnt_0_d;
  logic               gnt_1_q, gnt_1_d;
  logic               r_en_q;
  logic               aborted_q, aborted_d;

  logic               elig_0, elig_1, pick_1;
  logic [BURST_W-1:0] len_sel;

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  assign elig_0  = req_0 && (len_0 != '0);
  assign elig_1  = req_1 && (len_1 != '0);
  assign pick_1  = elig_1 && (!elig_0 || favour_q);
  assign len_sel = pick_1 ? len_1 : len_0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    favour_d  = favour_q;
    gnt_0_d   = gnt_0_q;
    gnt_1_d   = gnt_1_q;
    aborted_d = aborted_q;
    fifo_r_en = 1'b0;
`ifdef STALL_TIMEOUT_EN
    stall_d   = stall_q;
`endif
    case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        if (fifo_ready && (elig_0 || elig_1)) begin
          cnt_d   = (len_sel > MAX_LEN) ? MAX_LEN : len_sel;
          gnt_0_d = !pick_1;
          gnt_1_d = pick_1;
          state_d = READ;
        end
      end
      READ: begin
        if (!fifo_empty && (cnt_q != '0)) begin
          fifo_r_en = 1'b1;
          cnt_d     = cnt_q - 1'b1;
`ifdef STALL_TIMEOUT_EN
          stall_d   = '0;
`endif
          if (cnt_q == BURST_W'(1)) state_d = DRAIN;
        end
`ifdef STALL_TIMEOUT_EN
        else if (cnt_q != '0) begin
          // No read is outstanding on a stall, so DRAIN can be skipped.
          if (stall_q == STALL_W'(TIMEOUT - 1)) begin
            stall_d   = '0;
            aborted_d = 1'b1;
            state_d   = DONE;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      DRAIN: state_d = DONE;
      DONE: begin
        favour_d = gnt_0_q;
        gnt_0_d  = 1'b0;
        gnt_1_d  = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      favour_q  <= 1'b0;
      gnt_0_q   <= 1'b0;
      gnt_1_q   <= 1'b0;
      r_en_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      favour_q  <= favour_d;
      gnt_0_q   <= gnt_0_d;
      gnt_1_q   <= gnt_1_d;
      r_en_q    <= fifo_r_en;
      aborted_q <= aborted_d;
    end
  end

`ifdef STALL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`endif

  assign gnt_0      = gnt_0_q;
  assign gnt_1      = gnt_1_q;
  assign rd_data    = fifo_r_data;
  // The FIFO returns data one cycle after the strobe.
  assign rd_valid_0 = r_en_q && gnt_0_q;
  assign rd_valid_1 = r_en_q && gnt_1_q;
  assign done_0     = (state_q == DONE) && gnt_0_q;
  assign done_1     = (state_q == DONE) && gnt_1_q;
  assign abort      = (state_q == DONE) && aborted_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_packet_read_arbiter.sv
module tb_packet_read_arbiter;

  localparam int B_G0 = 8, B_G1 = 7, B_REN = 6, B_RV0 = 5, B_RV1 = 4;
  localparam int B_D0 = 3, B_D1 = 2, B_AB = 1, B_BUSY = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic [6:0] len_0 = '0, len_1 = '0;
  logic       fifo_ready = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_r_data = '0;
  logic       fifo_r_en, gnt_0, gnt_1, rd_valid_0, rd_valid_1;
  logic       done_0, done_1, abort, busy;
  logic [7:0] rd_data;
  logic [8:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  logic       stall = 1'b0;
  logic       fifo_flush = 1'b0;

  assign fifo_empty = stall || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_r_en) begin
      fifo_r_data <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 8'd1;
    end
  end

  packet_read_arbiter #(
    .DATA_W(8), .MAX_BURST(64), .BURST_W(7), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .len_0(len_0), .req_1(req_1), .len_1(len_1),
    .fifo_ready(fifo_ready), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
    .fifo_r_en(fifo_r_en), .gnt_0(gnt_0), .gnt_1(gnt_1), .rd_data(rd_data),
    .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
    .done_0(done_0), .done_1(done_1), .abort(abort), .busy(busy)
  );

  assign obs = {gnt_0, gnt_1, fifo_r_en, rd_valid_0, rd_valid_1,
                done_0, done_1, abort, busy};

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_flush = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0; len_0 = '0; len_1 = '0;
    stall = 1'b0; fifo_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; fifo_flush = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== 9'b0) $display("FAIL reset_outputs: got %b expected %b", obs, 9'b0);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== 9'b0) $display("FAIL reset_idle: got %b expected %b", obs, 9'b0);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [8:0] exp;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    req_0 = 1'b1; len_0 = 7'd4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = '0;
      exp[B_G0]   = (k >= 1 && k <= 6);
      exp[B_REN]  = (k >= 1 && k <= 4);
      exp[B_RV0]  = (k >= 2 && k <= 5);
      exp[B_D0]   = (k == 6);
      exp[B_BUSY] = (k >= 1 && k <= 6);
      n_checks++;
      if (obs !== exp) $display("FAIL basic_cycle%0d: got %b expected %b", k, obs, exp);
      else n_pass++;
      if (k >= 2 && k <= 5) begin
        exp_d = 8'hA0 + 8'(k - 2);
        n_checks++;
        if (rd_data !== exp_d) $display("FAIL basic_data%0d: got %h expected %h", k, rd_data, exp_d);
        else n_pass++;
      end
      if (k == 1) req_0 = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int         winners [4];
    int         nd = 0;
    int         errs = 0;
    logic [7:0] exp_d = 8'hC0;
    do_reset();
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    req_0 = 1'b1; len_0 = 7'd2;
    req_1 = 1'b1; len_1 = 7'd2;
    for (int c = 0; c < 40 && nd < 4; c++) begin
      @(negedge clk);
      if ((gnt_0 && gnt_1) || (rd_valid_0 && !gnt_0) || (rd_valid_1 && !gnt_1)) errs++;
      if (rd_valid_0 || rd_valid_1) begin
        if (rd_data !== exp_d) errs++;
        exp_d = exp_d + 8'd1;
      end
      if (done_0 || done_1) begin
        winners[nd] = done_1 ? 1 : 0;
        nd++;
        if (nd == 4) begin req_0 = 1'b0; req_1 = 1'b0; end
      end
    end
    n_checks++;
    if (nd !== 4) $display("FAIL rr_done_count: got %0d expected 4", nd);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i < nd && winners[i] === (i % 2)) n_pass++;
      else $display("FAIL rr_winner%0d: got %0d expected %0d", i, (i < nd) ? winners[i] : -1, i % 2);
    end
    n_checks++;
    if (errs !== 0 || exp_d !== 8'hC8)
      $display("FAIL rr_overlap_data: got errs=%0d next=%h expected errs=0 next=c8", errs, exp_d);
    else n_pass++;
  endtask

  task automatic test_clamp();
    int         strobes = 0, valids = 0, errs = 0;
    logic       seen_done = 1'b0;
    logic [7:0] exp_d = 8'h00;
    do_reset();
    for (int i = 0; i < 70; i++) push(8'(i));
    req_1 = 1'b1; len_1 = 7'd100;
    for (int c = 0; c < 120 && !seen_done; c++) begin
      @(negedge clk);
      if (fifo_r_en) strobes++;
      if (rd_valid_0 || gnt_0) errs++;
      if (rd_valid_1) begin
        valids++;
        if (rd_data !== exp_d) errs++;
        exp_d = exp_d + 8'd1;
      end
      if (done_1) seen_done = 1'b1;
      // Request dropped and length changed after grant: both must be ignored.
      if (c == 0) begin req_1 = 1'b0; len_1 = 7'd5; end
    end
    n_checks++;
    if (!seen_done) $display("FAIL clamp_done: got 0 expected 1");
    else n_pass++;
    n_checks++;
    if (strobes !== 64) $display("FAIL clamp_strobes: got %0d expected 64", strobes);
    else n_pass++;
    n_checks++;
    if (valids !== 64 || errs !== 0)
      $display("FAIL clamp_bytes: got valids=%0d errs=%0d expected valids=64 errs=0", valids, errs);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL clamp_idle: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    int         strobes = 0, errs = 0, done_k = 0;
    logic [7:0] exp_d = 8'hB0;
    do_reset();
    for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i));
    req_0 = 1'b1; len_0 = 7'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      stall = (k >= 2 && k <= 6);
      #1;
      if (k == 1) req_0 = 1'b0;
      if (fifo_r_en) strobes++;
      if (stall && fifo_r_en) errs++;
      if (stall && !gnt_0) errs++;
      if (rd_valid_0) begin
        if (rd_data !== exp_d) errs++;
        exp_d = exp_d + 8'd1;
      end
      if (done_0) begin
        done_k = k;
        if (abort) errs++;
      end
    end
    n_checks++;
    if (strobes !== 3) $display("FAIL stall_strobes: got %0d expected 3", strobes);
    else n_pass++;
    n_checks++;
    if (done_k !== 10) $display("FAIL stall_done_cycle: got %0d expected 10", done_k);
    else n_pass++;
    n_checks++;
    if (errs !== 0 || exp_d !== 8'hB3)
      $display("FAIL stall_behaviour: got errs=%0d next=%h expected errs=0 next=b3", errs, exp_d);
    else n_pass++;
  endtask

  task automatic test_no_grant();
    do_reset();
    push(8'h11); push(8'h22);
    req_0 = 1'b1; len_0 = 7'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 9'b0) $display("FAIL len0_cycle%0d: got %b expected %b", k, obs, 9'b0);
      else n_pass++;
    end
    fifo_ready = 1'b0; len_0 = 7'd2;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 9'b0) $display("FAIL notready_cycle%0d: got %b expected %b", k, obs, 9'b0);
      else n_pass++;
    end
    // Requester 0 is favoured after reset but ineligible with len 0.
    fifo_ready = 1'b1; len_0 = 7'd0; req_1 = 1'b1; len_1 = 7'd2;
    @(negedge clk);
    req_1 = 1'b0;
    n_checks++;
    if ({gnt_0, gnt_1} !== 2'b01) $display("FAIL len0_other_wins: got %b expected 01", {gnt_0, gnt_1});
    else n_pass++;
    repeat (8) @(negedge clk);
    n_checks++;
    if (obs !== 9'b0) $display("FAIL len0_after: got %b expected %b", obs, 9'b0);
    else n_pass++;
    req_0 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int seen_done = 0;
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
    req_0 = 1'b1; len_0 = 7'd4;
    @(negedge clk);
    req_0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (obs !== 9'b0) $display("FAIL midreset_outputs: got %b expected %b", obs, 9'b0);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_0 || done_1 || busy) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) $display("FAIL midreset_no_done: got %0d expected 0", seen_done);
    else n_pass++;
  endtask

`ifdef STALL_TIMEOUT_EN
  task automatic test_timeout();
    logic [8:0] exp;
    do_reset();
    push(8'hE0);
    req_0 = 1'b1; len_0 = 7'd4;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp = '0;
      exp[B_G0]   = (k <= 10);
      exp[B_REN]  = (k == 1);
      exp[B_RV0]  = (k == 2);
      exp[B_D0]   = (k == 10);
      exp[B_AB]   = (k == 10);
      exp[B_BUSY] = (k <= 10);
      n_checks++;
      if (obs !== exp) $display("FAIL timeout_cycle%0d: got %b expected %b", k, obs, exp);
      else n_pass++;
      if (k == 1) req_0 = 1'b0;
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_clamp();
    test_stall();
    test_no_grant();
    test_reset_mid_burst();
`ifdef STALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
